// File: rtl/input_conditioner_if.sv
// ---------------------------------------------------------------------------
// | Module   : input_conditioner_if                                         |
// | Brief    : Board-side bundle of raw button/switch pins and their        |
// |            conditioned levels, pulses and toggle states.                |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

interface input_conditioner_if;
   logic [3:0] btn;
   logic [3:0] sw;
   logic [3:0] btn_db;
   logic [3:0] btn_rise;
   logic [3:0] btn_tgl;
   logic [3:0] sw_db;
   logic [3:0] sw_chg;

   // Board side: drives the raw pins and consumes the clean signals.
   modport master (
      output btn,
      output sw,
      input  btn_db,
      input  btn_rise,
      input  btn_tgl,
      input  sw_db,
      input  sw_chg
   );

   // Conditioner side.
   modport slave (
      input  btn,
      input  sw,
      output btn_db,
      output btn_rise,
      output btn_tgl,
      output sw_db,
      output sw_chg
   );
endinterface

`default_nettype wire

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// | Module   : input_conditioner                                            |
// | Brief    : Synchronises and debounces four buttons and four switches;   |
// |            produces clean levels, rise/change pulses and button toggles.|
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input_conditioner_if.slave  bus
);

   localparam int              c_num_ch = 8;
   localparam logic [CNT_W-1:0] c_last  = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channels 0..3 are BTN0..BTN3, channels 4..7 are SW0..SW3.
   logic [c_num_ch-1:0] w_raw;
   logic [c_num_ch-1:0] w_db;
   logic [c_num_ch-1:0] w_accept;
   logic [3:0]          w_btn_s2;
   logic [3:0]          w_btn_press;

   logic [3:0]          r_btn_rise;
   logic [3:0]          r_btn_tgl;
   logic [3:0]          r_sw_chg;

   assign w_raw = {bus.sw, bus.btn};

   generate
      for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_ch
         logic             r_s1;
         logic             r_s2;
         logic             r_db;
         logic [CNT_W-1:0] r_cnt;

         // Two-flop synchroniser followed by a restart-on-bounce stability counter.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1  <= 1'b0;
               r_s2  <= 1'b0;
               r_db  <= 1'b0;
               r_cnt <= '0;
            end else begin
               r_s1 <= w_raw[gi];
               r_s2 <= r_s1;
               if (r_s2 == r_db) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_last) begin
                  r_db  <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end

         // High on the edge where the debounced level is about to flip.
         assign w_accept[gi] = (r_s2 != r_db) && (r_cnt == c_last);
         assign w_db[gi]     = r_db;

         if (gi < 4) begin : g_btn
            assign w_btn_s2[gi] = r_s2;
         end
      end
   endgenerate

   // A button press is an accepted transition towards 1.
   assign w_btn_press = w_accept[3:0] & w_btn_s2;

   // Edge pulses and toggles register on the same edge that updates the level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_rise <= 4'b0000;
         r_btn_tgl  <= 4'b0000;
         r_sw_chg   <= 4'b0000;
      end else begin
         r_btn_rise <= w_btn_press;
         r_btn_tgl  <= r_btn_tgl ^ w_btn_press;
         r_sw_chg   <= w_accept[7:4];
      end
   end

   assign bus.btn_db   = w_db[3:0];
   assign bus.sw_db    = w_db[7:4];
   assign bus.btn_rise = r_btn_rise;
   assign bus.btn_tgl  = r_btn_tgl;
   assign bus.sw_chg   = r_sw_chg;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// | Module   : tb_input_conditioner                                         |
// | Brief    : Scoreboard bench for input_conditioner with a history-based  |
// |            reference model, directed scenarios and random bouncing.     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_input_conditioner;

   localparam int D = 4;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   input_conditioner_if bus ();

   input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard bookkeeping.
   logic [19:0] exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;

   // Reference model: a level is accepted when the last D synchronised
   // samples (raw samples taken two or more edges ago) all differ from it.
   bit          hist[8][$];
   logic [7:0]  m_db   = '0;
   logic [3:0]  m_rise = '0;
   logic [3:0]  m_tgl  = '0;
   logic [3:0]  m_chg  = '0;

   always @(posedge clk) begin
      logic [7:0] raw;
      logic [7:0] acc;
      bit         stable;
      raw = {bus.sw, bus.btn};
      acc = '0;
      cyc++;
      if (!rst_n) begin
         for (int c = 0; c < 8; c++) begin
            hist[c].delete();
            for (int j = 0; j < D + 1; j++) hist[c].push_back(1'b0);
         end
         m_db   = '0;
         m_rise = '0;
         m_tgl  = '0;
         m_chg  = '0;
      end else begin
         for (int c = 0; c < 8; c++) begin
            stable = 1'b1;
            for (int j = 2; j <= D + 1; j++)
               if (hist[c][hist[c].size() - j] == m_db[c]) stable = 1'b0;
            acc[c] = stable;
            hist[c].push_back(raw[c]);
            if (hist[c].size() > 16) void'(hist[c].pop_front());
         end
         m_db   = m_db ^ acc;
         m_rise = acc[3:0] & m_db[3:0];
         m_chg  = acc[7:4];
         m_tgl  = m_tgl ^ m_rise;
      end
      exp_q.push_back({m_tgl, m_rise, m_chg, m_db});
   end

   // Monitor: every cycle the DUT presents a full output word; compare it.
   always @(posedge clk) begin
      logic [19:0] exp_v;
      logic [19:0] act_v;
      #1;
      act_v = {bus.btn_tgl, bus.btn_rise, bus.sw_chg, bus.sw_db, bus.btn_db};
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL cycle %0d no_expected: got %h required an expected entry", cyc, act_v);
      end else begin
         exp_v = exp_q.pop_front();
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle %0d outputs{tgl,rise,chg,sw_db,btn_db}: got %h required %h",
                     cyc, act_v, exp_v);
         end
      end
   end

   // Inputs change 2 time units after the active edge.
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [3:0] b, input logic [3:0] s, input int n);
      bus.btn = b;
      bus.sw  = s;
      wait_cycles(n);
   endtask

   initial begin
      logic [3:0] b;
      logic [3:0] s;
      bus.btn = 4'h0;
      bus.sw  = 4'h0;
      #2;

      // Inputs held high through reset.
      rst_n = 1'b0;
      drive(4'hF, 4'hF, 5);
      rst_n = 1'b1;
      wait_cycles(10);
      drive(4'h0, 4'h0, 10);

      // Clean press and release.
      drive(4'h1, 4'h0, 20);
      drive(4'h0, 4'h0, 10);

      // Bounce on btn[1], then stable high.
      for (int j = 0; j < 6; j++) drive((j % 2 == 0) ? 4'h2 : 4'h0, 4'h0, 2);
      drive(4'h2, 4'h0, 12);
      drive(4'h0, 4'h0, 10);

      // Glitch shorter than, then equal to, the debounce window.
      drive(4'h0, 4'h4, 3);
      drive(4'h0, 4'h0, 10);
      drive(4'h0, 4'h4, 4);
      drive(4'h0, 4'h0, 12);

      // Simultaneous independent channels.
      drive(4'h5, 4'hA, 10);
      drive(4'h0, 4'h0, 10);

      // Reset mid-count.
      drive(4'h8, 4'h0, 3);
      rst_n = 1'b0;
      wait_cycles(1);
      rst_n = 1'b1;
      wait_cycles(10);
      drive(4'h0, 4'h0, 10);

      // Random bouncing with occasional resets.
      b = 4'h0;
      s = 4'h0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
            if ($urandom_range(0, 5) == 0) s[c] = ~s[c];
         end
         if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         drive(b, s, $urandom_range(1, 3));
      end
      rst_n = 1'b1;
      drive(4'h0, 4'h0, 12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
